// File: rtl/array_loader_pkg.sv
// -----------------------------------------------------------------------------
// array_loader_pkg
//   Shared definitions for the array loader: the controller state encoding
//   and the default element / address widths.
//   Optional feature macro used by the top: ARRAY_LOADER_RUN_COUNT_EN.
// -----------------------------------------------------------------------------
package array_loader_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 4;
  localparam int unsigned RUN_COUNT_W = 8;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_e;

endpackage : array_loader_pkg

// File: rtl/array_loader_counter.sv
// -----------------------------------------------------------------------------
// loader_counter
//   Element count register for the array loader. Counts accepted elements
//   from 0 up to 2**ADDR_W and reports when the array is full.
//
//   Ports
//     clk_i    : clock, rising edge
//     rst_i    : asynchronous active-high reset, clears the count
//     clr_i    : synchronous clear (takes priority over inc_i)
//     inc_i    : count one accepted element (ignored while full)
//     count_o  : current element count, ADDR_W+1 bits wide
//     full_o   : count equals 2**ADDR_W
// -----------------------------------------------------------------------------
module loader_counter
  import array_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [ADDR_W:0] count_o,
  output logic            full_o
);

  logic [ADDR_W:0] count_q;
  logic [ADDR_W:0] count_d;

  // The count never exceeds 2**ADDR_W, so the top bit alone marks "full".
  assign full_o  = count_q[ADDR_W];
  assign count_o = count_q;

  // NOTE: every variable assigned in an always_comb gets a default first;
  // a missing branch would otherwise hold the old value and infer a latch.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !full_o) begin
      count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : loader_counter

// File: rtl/array_loader.sv
// -----------------------------------------------------------------------------
// array_loader
//   Streams elements from a producer into an external array memory, then
//   hands the element count to a sortedness checker and latches its verdict.
//   Controller states: LOAD -> START -> WAIT -> RESULT.
//
//   Ports
//     clock, reset          : clock (rising edge), async active-high reset
//     in_valid, in_data     : producer element
//     in_ready              : element accepted this cycle (LOAD, not full,
//                             no commit)
//     commit                : end of array, start a check run
//     mem_we/addr/wdata     : write port into the array memory
//     length                : element count frozen at commit
//     go                    : checker go, registered; 1->0 starts a run
//     chk_done, chk_sorted  : checker completion and verdict
//     result_valid/_sorted  : latched outcome of the last run
//     overflow              : sticky, an element arrived while full
//     run_count             : completed runs, saturating at 255
//                             (only with ARRAY_LOADER_RUN_COUNT_EN defined)
// -----------------------------------------------------------------------------
module array_loader
  import array_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              commit,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   length,
  output logic              go,
  input  logic              chk_done,
  input  logic              chk_sorted,
  output logic              result_valid,
  output logic              result_sorted,
`ifdef ARRAY_LOADER_RUN_COUNT_EN
  output logic [RUN_COUNT_W-1:0] run_count,
`endif
  output logic              overflow
);

  state_e          state_q, state_d;
  logic [ADDR_W:0] length_q, length_d;
  logic            go_q, go_d;
  logic            rvalid_q, rvalid_d;
  logic            rsorted_q, rsorted_d;
  logic            ovf_q, ovf_d;

  logic [ADDR_W:0] count;
  logic            full;
  logic            accept;
  logic            cnt_clr;
  logic            ready_c;

  loader_counter #(
    .ADDR_W (ADDR_W)
  ) u_counter (
    .clk_i   (clock),
    .rst_i   (reset),
    .clr_i   (cnt_clr),
    .inc_i   (accept),
    .count_o (count),
    .full_o  (full)
  );

  always_comb begin
    state_d   = state_q;
    length_d  = length_q;
    rvalid_d  = rvalid_q;
    rsorted_d = rsorted_q;
    ovf_d     = ovf_q;
    ready_c   = 1'b0;
    accept    = 1'b0;
    cnt_clr   = 1'b0;

    unique case (state_q)
      LOAD: begin
        // Commit wins over a same-cycle element. Reset gating keeps the
        // write strobe quiet while reset is held.
        ready_c = !full && !commit && !reset;
        accept  = in_valid && ready_c;
        if (commit) begin
          state_d  = START;
          length_d = count;
        end else if (in_valid && full) begin
          ovf_d = 1'b1;
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (chk_done) begin
          state_d   = RESULT;
          rvalid_d  = 1'b1;
          rsorted_d = chk_sorted;
        end
      end
      RESULT: begin
        // A new element restarts loading from address 0; it is only taken
        // in the following LOAD cycle, so the producer simply holds it.
        if (in_valid) begin
          state_d  = LOAD;
          cnt_clr  = 1'b1;
          rvalid_d = 1'b0;
          ovf_d    = 1'b0;
        end else if (commit) begin
          state_d  = START;
          rvalid_d = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    // go is low exactly while the controller sits in START; registering
    // the decoded next state keeps every input off the go path.
    go_d = (state_d != START);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= LOAD;
      length_q  <= '0;
      go_q      <= 1'b1;
      rvalid_q  <= 1'b0;
      rsorted_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      length_q  <= length_d;
      go_q      <= go_d;
      rvalid_q  <= rvalid_d;
      rsorted_q <= rsorted_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef ARRAY_LOADER_RUN_COUNT_EN
  logic [RUN_COUNT_W-1:0] run_cnt_q, run_cnt_d;

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (state_q == WAIT && chk_done && run_cnt_q != {RUN_COUNT_W{1'b1}}) begin
      run_cnt_d = run_cnt_q + {{(RUN_COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

  assign run_count = run_cnt_q;
`endif

  // Write port is combinational so an element lands in the same cycle it
  // is accepted. The array memory itself lives outside and is never reset.
  assign in_ready      = ready_c;
  assign mem_we        = accept;
  assign mem_addr      = count[ADDR_W-1:0];
  assign mem_wdata     = in_data;
  assign length        = length_q;
  assign go            = go_q;
  assign result_valid  = rvalid_q;
  assign result_sorted = rsorted_q;
  assign overflow      = ovf_q;

endmodule : array_loader

// File: tb/tb_array_loader.sv
// -----------------------------------------------------------------------------
// tb_array_loader
//   Self-checking bench for array_loader. A transaction-level model tracks
//   how many elements the current array holds, whether a result is being
//   held, the expected length / overflow / verdict and the number of runs.
//   Define ARRAY_LOADER_RUN_COUNT_EN to also exercise run_count.
// -----------------------------------------------------------------------------
module tb_array_loader;
  import array_loader_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              commit;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W:0]   length;
  logic              go;
  logic              chk_done;
  logic              chk_sorted;
  logic              result_valid;
  logic              result_sorted;
  logic              overflow;
`ifdef ARRAY_LOADER_RUN_COUNT_EN
  logic [7:0]        run_count;
`endif

  array_loader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .commit        (commit),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .length        (length),
    .go            (go),
    .chk_done      (chk_done),
    .chk_sorted    (chk_sorted),
    .result_valid  (result_valid),
    .result_sorted (result_sorted),
`ifdef ARRAY_LOADER_RUN_COUNT_EN
    .run_count     (run_count),
`endif
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model (transaction level)
  int n_loaded;   // elements accepted into the current array
  bit in_result;  // a verdict is being held
  int exp_len;
  bit exp_ovf;
  bit exp_rv;
  bit exp_rs;
  int runs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    n_loaded  = 0;
    in_result = 0;
    exp_len   = 0;
    exp_ovf   = 0;
    exp_rv    = 0;
    exp_rs    = 0;
    runs      = 0;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    reset    = 1'b1;
    in_valid = 1'b1;
    #1;
    check({tag, "_go"},     go, 1);
    check({tag, "_rvalid"}, result_valid, 0);
    check({tag, "_rsort"},  result_sorted, 0);
    check({tag, "_ovf"},    overflow, 0);
    check({tag, "_len"},    length, 0);
    check({tag, "_we"},     mem_we, 0);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    reset    = 1'b0;
    model_reset();
  endtask

  // Present one element; leaving RESULT costs one extra (held) cycle.
  task automatic push(input logic [DATA_W-1:0] d);
    bit acc;
    in_valid = 1'b1;
    in_data  = d;
    if (in_result) begin
      @(negedge clock);
      check("exit_ready", in_ready, 0);
      check("exit_we", mem_we, 0);
      check("exit_rvalid_held", result_valid, 1);
      tick();
      in_result = 0;
      n_loaded  = 0;
      exp_rv    = 0;
      exp_ovf   = 0;
    end
    acc = (n_loaded < DEPTH);
    @(negedge clock);
    check("in_ready", in_ready, acc);
    check("mem_we", mem_we, acc);
    if (acc) begin
      check("mem_addr", mem_addr, n_loaded);
      check("mem_wdata", mem_wdata, d);
    end
    check("load_go", go, 1);
    check("load_rvalid", result_valid, 0);
    tick();
    in_valid = 1'b0;
    if (acc) n_loaded++;
    else     exp_ovf = 1;
  endtask

  // Idle cycles, optionally with stray chk_done pulses that must be ignored.
  task automatic idle(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      chk_done   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      chk_sorted = 1'($urandom_range(0, 1));
      @(negedge clock);
      check("idle_go", go, 1);
      check("idle_we", mem_we, 0);
      check("idle_ready", in_ready, (!in_result && n_loaded < DEPTH));
      check("idle_rvalid", result_valid, exp_rv);
      check("idle_ovf", overflow, exp_ovf);
      if (in_result) check("idle_rsort", result_sorted, exp_rs);
      tick();
      chk_done = 1'b0;
    end
  endtask

  // Commit, then let the checker answer after 'delay' WAIT cycles.
  task automatic run(input bit sorted, input int delay, input bit with_valid);
    commit   = 1'b1;
    in_valid = with_valid;
    in_data  = $urandom;
    @(negedge clock);
    check("commit_ready", in_ready, 0);
    check("commit_we", mem_we, 0);
    check("commit_go", go, 1);
    tick();
    commit   = 1'b0;
    in_valid = 1'b0;
    if (in_result) exp_ovf = 0;
    else           exp_len = n_loaded;
    in_result = 0;
    exp_rv    = 0;
    @(negedge clock);
    check("start_go", go, 0);
    check("start_len", length, exp_len);
    check("start_ready", in_ready, 0);
    check("start_rvalid", result_valid, 0);
    check("start_ovf", overflow, exp_ovf);
    tick();
    for (int i = 0; i < delay; i++) begin
      @(negedge clock);
      check("wait_go", go, 1);
      check("wait_rvalid", result_valid, 0);
      check("wait_ready", in_ready, 0);
      tick();
    end
    chk_done   = 1'b1;
    chk_sorted = sorted;
    @(negedge clock);
    check("done_go", go, 1);
    tick();
    chk_done   = 1'b0;
    chk_sorted = ~sorted;
    in_result  = 1;
    exp_rv     = 1;
    exp_rs     = sorted;
    runs++;
    @(negedge clock);
    check("res_rvalid", result_valid, 1);
    check("res_rsort", result_sorted, sorted);
    check("res_len", length, exp_len);
    check("res_go", go, 1);
    check("res_ready", in_ready, 0);
`ifdef ARRAY_LOADER_RUN_COUNT_EN
    check("run_count", run_count, (runs > 255) ? 255 : runs);
`endif
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset      = 1'b1;
    in_valid   = 1'b1;
    in_data    = '0;
    commit     = 1'b0;
    chk_done   = 1'b0;
    chk_sorted = 1'b0;
    model_reset();

    // Reset state, with in_valid held high to show no write escapes.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_go", go, 1);
    check("rst_we", mem_we, 0);
    check("rst_len", length, 0);
    check("rst_rvalid", result_valid, 0);
    check("rst_rsort", result_sorted, 0);
    check("rst_ovf", overflow, 0);
`ifdef ARRAY_LOADER_RUN_COUNT_EN
    check("rst_run_count", run_count, 0);
`endif
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    reset    = 1'b0;
    idle(1, 0);

    // Three elements then a sorted verdict.
    push(32'd3);
    push(32'd5);
    push(32'd9);
    run(1'b1, 2, 1'b0);
    idle(2, 1);

    // Fill to capacity plus one dropped element.
    for (int i = 0; i < DEPTH + 1; i++) push($urandom);
    idle(1, 0);
    run(1'b0, 1, 1'b0);
    idle(1, 1);

    // Commit alone from RESULT re-runs with the same length, clears overflow.
    run(1'b1, 0, 1'b0);

    // Reset while waiting for the checker, then a stray chk_done in LOAD.
    push($urandom);
    push($urandom);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    async_reset("rst_wait");
    chk_done   = 1'b1;
    chk_sorted = 1'b1;
    tick();
    chk_done = 1'b0;
    idle(1, 0);

    // Empty array still runs START/WAIT.
    run(1'b1, 1, 1'b0);

    // Commit and in_valid together in LOAD.
    push($urandom);
    push($urandom);
    run(1'b0, 1, 1'b1);

    // Reset while holding a result.
    async_reset("rst_result");

    // Randomized runs.
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(0, DEPTH + 2);
      if (n > 0 || !in_result) begin
        for (int k = 0; k < n; k++) begin
          push($urandom);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), 1);
        end
      end
      run(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
      idle($urandom_range(0, 2), 1);
    end

`ifdef ARRAY_LOADER_RUN_COUNT_EN
    // Saturation of the run counter.
    async_reset("rst_cnt");
    for (int r = 0; r < 3; r++) run(1'b1, 0, 1'b0);
    for (int r = 0; r < 297; r++) run(1'b0, 0, 1'b0);
    check("run_count_sat", run_count, 255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_array_loader
